lsu_mem_master: RTL and testbench

- Load/store unit and initiator side of the word-addressed data memory port: `write_enable`, `address`, `data_in`, `data_out`.
- Accepts RV32I byte, halfword and word load/store requests from the core datapath.
- Converts byte addresses to word indices and does sign/zero extension on loads.
- Sub-word stores are done as read-modify-write sequences, because the memory has no byte enables.

---
 rtl/riscy_lsu_pkg.sv | 37 +++
 rtl/lsu_mem_master_lane_align.sv | 58 +++++
 rtl/lsu_mem_master.sv | 112 +++++++++++
 tb/tb_lsu_mem_master.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_lsu_pkg.sv
// Shared constants, state encoding and request legality check for the RV32I load/store unit.
package riscy_lsu_pkg;

   localparam int MEM_WORDS_DEFAULT = 4096;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic [2:0] {
      LSU_IDLE    = 3'd0,
      LSU_RD_ADDR = 3'd1,
      LSU_RD_DATA = 3'd2,
      LSU_WR      = 3'd3,
      LSU_RESP    = 3'd4
   } lsu_state_t;

   // A request is rejected for an unknown funct3, an unsigned store, misalignment or a word index past the memory.
   function automatic logic lsu_req_error(input logic        write,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr,
                                          input int          mem_words);
      logic w_bad_f3;
      logic w_bad_store;
      logic w_misalign;
      logic w_out_of_range;
      w_bad_f3       = !(funct3 inside {FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU});
      w_bad_store    = write && (funct3 == FUNCT3_BU || funct3 == FUNCT3_HU);
      w_misalign     = ((funct3 == FUNCT3_H || funct3 == FUNCT3_HU) && addr[0]) ||
                       ((funct3 == FUNCT3_W) && (addr[1:0] != 2'b00));
      w_out_of_range = ({2'b00, addr[31:2]} >= 32'(mem_words));
      return w_bad_f3 || w_bad_store || w_misalign || w_out_of_range;
   endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Little-endian lane extraction with sign/zero extension, and sub-word merge into a read word.
module lsu_lane_align
   import riscy_lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_mem_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_val,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // NOTE: every variable is given a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      w_byte = 8'h00;
      case (i_addr_lo)
         2'd0:    w_byte = i_mem_word[7:0];
         2'd1:    w_byte = i_mem_word[15:8];
         2'd2:    w_byte = i_mem_word[23:16];
         default: w_byte = i_mem_word[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];

      o_load_val = 32'h0;
      case (i_funct3)
         FUNCT3_B:  o_load_val = {{24{w_byte[7]}}, w_byte};
         FUNCT3_H:  o_load_val = {{16{w_half[15]}}, w_half};
         FUNCT3_W:  o_load_val = i_mem_word;
         FUNCT3_BU: o_load_val = {24'h0, w_byte};
         FUNCT3_HU: o_load_val = {16'h0, w_half};
         default:   o_load_val = 32'h0;
      endcase
   end

   // Only the addressed lane(s) change; every other bit of the read word passes through untouched.
   always_comb begin
      o_store_word = i_mem_word;
      case (i_funct3[1:0])
         2'b00: begin
            case (i_addr_lo)
               2'd0:    o_store_word[7:0]   = i_wdata[7:0];
               2'd1:    o_store_word[15:8]  = i_wdata[7:0];
               2'd2:    o_store_word[23:16] = i_wdata[7:0];
               default: o_store_word[31:24] = i_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
            else              o_store_word[15:0]  = i_wdata[15:0];
         end
         default: o_store_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store unit driving a word-addressed memory without byte enables; sub-word stores use read-modify-write.
module lsu_mem_master
   import riscy_lsu_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
   parameter int XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_error,
   output logic            mem_write_enable,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_data_in,
   input  logic [XLEN-1:0] mem_data_out
);

   lsu_state_t      r_state;
   logic            r_write;
   logic [2:0]      r_funct3;
   logic [1:0]      r_addr_lo;
   logic [XLEN-1:0] r_wdata;
   logic            r_err;
   logic [XLEN-1:0] r_rdata;
   logic [XLEN-1:0] r_mem_addr;
   logic [XLEN-1:0] r_mem_wdata;

   logic            w_accept;
   logic            w_err;
   logic [XLEN-1:0] w_load_val;
   logic [XLEN-1:0] w_store_word;

   assign req_ready        = (r_state == LSU_IDLE) && !rst;
   assign w_accept         = req_valid && req_ready;
   assign w_err            = lsu_req_error(req_write, req_funct3, req_addr, MEM_WORDS);
   assign resp_valid       = (r_state == LSU_RESP);
   assign resp_error       = (r_state == LSU_RESP) && r_err;
   assign resp_rdata       = r_rdata;
   assign mem_write_enable = (r_state == LSU_WR) && !rst;
   assign mem_address      = r_mem_addr;
   assign mem_data_in      = r_mem_wdata;

   lsu_lane_align u_lane_align (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr_lo),
      .i_mem_word   (mem_data_out),
      .i_wdata      (r_wdata),
      .o_load_val   (w_load_val),
      .o_store_word (w_store_word)
   );

   // NOTE: all state below is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= LSU_IDLE;
         r_write     <= 1'b0;
         r_funct3    <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_wdata     <= '0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            LSU_IDLE: begin
               if (w_accept) begin
                  r_write   <= req_write;
                  r_funct3  <= req_funct3;
                  r_addr_lo <= req_addr[1:0];
                  r_wdata   <= req_wdata;
                  r_err     <= w_err;
                  r_rdata   <= '0;
                  // Rejected requests leave the memory-side address untouched.
                  if (w_err) begin
                     r_state <= LSU_RESP;
                  end else begin
                     r_mem_addr <= {2'b00, req_addr[XLEN-1:2]};
                     if (req_write && (req_funct3 == FUNCT3_W)) begin
                        r_mem_wdata <= req_wdata;
                        r_state     <= LSU_WR;
                     end else begin
                        r_state <= LSU_RD_ADDR;
                     end
                  end
               end
            end
            LSU_RD_ADDR: r_state <= LSU_RD_DATA;
            LSU_RD_DATA: begin
               if (r_write) begin
                  r_mem_wdata <= w_store_word;
                  r_state     <= LSU_WR;
               end else begin
                  r_rdata <= w_load_val;
                  r_state <= LSU_RESP;
               end
            end
            LSU_WR:   r_state <= LSU_RESP;
            LSU_RESP: r_state <= LSU_IDLE;
            default:  r_state <= LSU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and randomized traffic against a byte-level model.
module tb_lsu_mem_master;
   import riscy_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        mem_write_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_mem_master dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_error       (resp_error),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_data_out     (mem_data_out)
   );

   // Synchronous-read memory; preloads are routed through the same process.
   logic [31:0] mem [0:4095];
   logic        pre_en = 1'b0;
   logic [11:0] pre_idx = '0;
   logic [31:0] pre_val = '0;
   int          we_count = 0;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end else if (mem_write_enable) begin
         mem[mem_address[11:0]] <= mem_data_in;
         we_count <= we_count + 1;
      end
      mem_data_out <= mem[mem_address[11:0]];
   end

   // Reference model state: the memory contents as the architecture defines them.
   logic [31:0] ref_mem [0:4095];
   logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = 12'(idx);
      pre_val = val;
      ref_mem[idx] = val;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // Architectural model: byte arithmetic on ref_mem, latency from the request class.
   task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat, output int wes);
      int          size;
      int          sh;
      int          idx;
      logic [31:0] w;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      err  = !(f3 inside {legal_f3}) || (wr && f3[2]) ||
             ((addr % size) != 0) || ((addr / 4) >= 4096);
      rd   = '0;
      wes  = 0;
      if (err) begin
         lat = 1;
      end else begin
         idx = int'(addr / 4);
         sh  = int'(addr % 4) * 8;
         w   = ref_mem[idx];
         if (wr) begin
            for (int b = 0; b < size; b++) w[sh + 8*b +: 8] = wd[8*b +: 8];
            ref_mem[idx] = w;
            wes = 1;
            lat = (size == 4) ? 2 : 4;
         end else begin
            rd = w >> sh;
            if (size == 1)      rd = f3[2] ? {24'h0, rd[7:0]}  : {{24{rd[7]}}, rd[7:0]};
            else if (size == 2) rd = f3[2] ? {16'h0, rd[15:0]} : {{16{rd[15]}}, rd[15:0]};
            lat = 3;
         end
      end
   endtask

   // Issue one request, wait (bounded) for its response and report what was observed.
   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int wes, output logic resp_after);
      int we0;
      int cyc;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      cyc = 0;
      while (!req_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
      we0 = we_count;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      err = 1'b0;
      rd  = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = c;
            err = resp_error;
            rd  = resp_rdata;
            break;
         end
      end
      @(negedge clk);
      resp_after = resp_valid;
      wes = we_count - we0;
   endtask

   typedef struct {
      logic        pre;
      int          pre_idx;
      logic [31:0] pre_val;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_we;
      logic        chk_word;
      int          word_idx;
      logic [31:0] exp_word;
   } vec_t;

   vec_t        vecs[$];
   logic        o_err, m_err, o_after;
   logic [31:0] o_rd, m_rd, prev_ma, exp_ma, b2b_val;
   int          o_lat, o_wes, m_lat, m_wes, w0, resp_seen;
   logic        r_wr;
   logic [2:0]  r_f3;
   logic [29:0] r_word;
   logic [1:0]  r_low;
   logic [31:0] r_addr, r_wd;
   int          r_sel;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

      //                pre idx  pre_val       wr f3         addr       wdata         err rdata          lat we chk idx word
      vecs.push_back('{1'b0, 0, 32'h0,        1'b1, FUNCT3_W,  32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2, 1, 1'b1, 4, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_W,  32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 3, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b1, 4, 32'h11223344, 1'b1, FUNCT3_B,  32'h13,   32'h000000A5, 1'b0, 32'h0,        4, 1, 1'b1, 4, 32'hA5223344});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_B,  32'h13,   32'h0,        1'b0, 32'hFFFFFFA5, 3, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_BU, 32'h13,   32'h0,        1'b0, 32'h000000A5, 3, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_B,  32'h10,   32'h0,        1'b0, 32'h00000044, 3, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b1, 5, 32'hCAFEF00D, 1'b1, FUNCT3_H,  32'h16,   32'h00008001, 1'b0, 32'h0,        4, 1, 1'b1, 5, 32'h8001F00D});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_H,  32'h16,   32'h0,        1'b0, 32'hFFFF8001, 3, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_HU, 32'h16,   32'h0,        1'b0, 32'h00008001, 3, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_W,  32'h2,    32'h0,        1'b1, 32'h0,        1, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b1, FUNCT3_H,  32'h5,    32'h1234,     1'b1, 32'h0,        1, 0, 1'b1, 1, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, FUNCT3_W,  32'h4000, 32'h0,        1'b1, 32'h0,        1, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b0, 3'b011,    32'h0,    32'h0,        1'b1, 32'h0,        1, 0, 1'b0, 0, 32'h0});
      vecs.push_back('{1'b0, 0, 32'h0,        1'b1, FUNCT3_BU, 32'h10,   32'h000000FF, 1'b1, 32'h0,        1, 0, 1'b1, 4, 32'hA5223344});

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready_low", {31'b0, req_ready}, 32'd0);
      check("rst_we_low", {31'b0, mem_write_enable}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", {31'b0, req_ready}, 32'd1);
      check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("reset_resp_error", {31'b0, resp_error}, 32'd0);
      check("reset_we", {31'b0, mem_write_enable}, 32'd0);
      check("reset_rdata", resp_rdata, 32'd0);
      check("reset_mem_address", mem_address, 32'd0);
      check("reset_mem_data_in", mem_data_in, 32'd0);

      // Directed vector table
      foreach (vecs[i]) begin
         if (vecs[i].pre) preload(vecs[i].pre_idx, vecs[i].pre_val);
         prev_ma = mem_address;
         do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, o_err, o_rd, o_lat, o_wes, o_after);
         exp_ma = vecs[i].exp_err ? prev_ma : {2'b00, vecs[i].addr[31:2]};
         check($sformatf("vec%0d_error", i), {31'b0, o_err}, {31'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_rdata", i), o_rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_latency", i), o_lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_writes", i), o_wes, vecs[i].exp_we);
         check($sformatf("vec%0d_resp_one_cycle", i), {31'b0, o_after}, 32'd0);
         check($sformatf("vec%0d_mem_address", i), mem_address, exp_ma);
         if (vecs[i].chk_word)
            check($sformatf("vec%0d_word", i), mem[vecs[i].word_idx], vecs[i].exp_word);
      end

      // Back-to-back with req_valid held high: SW 0x20 then LW 0x20
      b2b_val = 32'h0BADF00D;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = FUNCT3_W;
      req_addr   = 32'h20;
      req_wdata  = b2b_val;
      check("b2b_ready_idle", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_write = 1'b0;
      @(negedge clk);
      check("b2b_ready_wr", {31'b0, req_ready}, 32'd0);
      check("b2b_we_wr", {31'b0, mem_write_enable}, 32'd1);
      check("b2b_we_addr", mem_address, 32'd8);
      check("b2b_we_data", mem_data_in, b2b_val);
      @(negedge clk);
      check("b2b_ready_resp", {31'b0, req_ready}, 32'd0);
      check("b2b_sw_resp", {31'b0, resp_valid}, 32'd1);
      @(negedge clk);
      check("b2b_ready_back", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b_lw_busy1", {30'b0, req_ready, resp_valid}, 32'd0);
      @(negedge clk);
      check("b2b_lw_busy2", {30'b0, req_ready, resp_valid}, 32'd0);
      @(negedge clk);
      check("b2b_lw_resp", {31'b0, resp_valid}, 32'd1);
      check("b2b_lw_rdata", resp_rdata, b2b_val);
      @(negedge clk);

      // Reset during RD_DATA of an SB: the read-modify-write must never write
      preload(8, 32'h55555555);
      w0 = we_count;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = FUNCT3_B;
      req_addr   = 32'h20;
      req_wdata  = 32'h000000A5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_ready_in_rst", {31'b0, req_ready}, 32'd0);
      check("rstmid_we_in_rst", {31'b0, mem_write_enable}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
      resp_seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (resp_valid) resp_seen++;
         @(negedge clk);
      end
      check("rstmid_no_resp", resp_seen, 0);
      check("rstmid_no_write", we_count - w0, 0);
      check("rstmid_word", mem[8], 32'h55555555);

      // Reset while in WR of an SW: the write strobe is gated off by reset
      preload(9, 32'h0F0F0F0F);
      w0 = we_count;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = FUNCT3_W;
      req_addr   = 32'h24;
      req_wdata  = 32'h12345678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstwr_we_gated", {31'b0, mem_write_enable}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      resp_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid) resp_seen++;
      end
      check("rstwr_no_resp", resp_seen, 0);
      check("rstwr_no_write", we_count - w0, 0);
      check("rstwr_word", mem[9], 32'h0F0F0F0F);
      do_req(1'b0, FUNCT3_B, 32'h20, 32'h0, o_err, o_rd, o_lat, o_wes, o_after);
      check("rstmid_reload", o_rd, 32'h00000055);

      // Randomized traffic against the model
      for (int k = 0; k < 16; k++) preload(k, $urandom);
      for (int n = 0; n < 250; n++) begin
         r_wr  = 1'($urandom_range(0, 1));
         r_sel = $urandom_range(0, 99);
         r_f3  = (r_sel < 85) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
         r_sel = $urandom_range(0, 99);
         if (r_sel < 6)       r_word = 30'(4096 + $urandom_range(0, 2000));
         else if (r_sel < 8)  r_word = 30'h3FFFFFFF;
         else                 r_word = 30'($urandom_range(0, 15));
         r_low = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0) begin
            if (r_f3[1:0] == 2'b01)      r_low[0] = 1'b0;
            else if (r_f3[1:0] == 2'b10) r_low = 2'b00;
         end
         r_addr  = {r_word, r_low};
         r_wd    = $urandom;
         prev_ma = mem_address;
         model(r_wr, r_f3, r_addr, r_wd, m_err, m_rd, m_lat, m_wes);
         do_req(r_wr, r_f3, r_addr, r_wd, o_err, o_rd, o_lat, o_wes, o_after);
         exp_ma = m_err ? prev_ma : {2'b00, r_addr[31:2]};
         check($sformatf("rnd%0d_error", n), {31'b0, o_err}, {31'b0, m_err});
         check($sformatf("rnd%0d_rdata", n), o_rd, m_rd);
         check($sformatf("rnd%0d_latency", n), o_lat, m_lat);
         check($sformatf("rnd%0d_writes", n), o_wes, m_wes);
         check($sformatf("rnd%0d_mem_address", n), mem_address, exp_ma);
         if (!m_err)
            check($sformatf("rnd%0d_word", n), mem[r_addr[13:2]], ref_mem[r_addr[13:2]]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
